// File: rtl/ex_stage_if.sv
// Bundle between ID/EX, the execute stage and EX/MEM, plus the front-end feedback path.
// Forwarding inputs only exist when EX_FORWARD_EN is defined.
interface ex_stage_if #(
  parameter int XLEN = 32,
  parameter int KW   = 2
);
  // Handshake: an instruction is consumed on a rising edge when valid_e=1 and
  // stall_m=0; while stall_m=1 the producer holds the E-bundle unchanged.
  logic            valid_e;
  logic            RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE;
  logic [2:0]      ALUControlE;
  logic [1:0]      ResultSrcE;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]      RdE;
  logic            stall_m;
`ifdef EX_FORWARD_EN
  logic [4:0]      Rs1E, Rs2E, RdW;
  logic [XLEN-1:0] ResultW;
  logic            RegWriteW;
`endif
  logic            stall_e;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            valid_m, RegWriteM, MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [XLEN-1:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]      RdM;
  logic [KW-1:0]   dbg_kill_cnt;

  modport master (
    output valid_e, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ALUControlE,
           ResultSrcE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, stall_m,
`ifdef EX_FORWARD_EN
           Rs1E, Rs2E, RdW, ResultW, RegWriteW,
`endif
    input  stall_e, redirect, redirect_pc, valid_m, RegWriteM, MemWriteM, ResultSrcM,
           ALUResultM, WriteDataM, PCPlus4M, RdM, dbg_kill_cnt
  );

  modport slave (
    input  valid_e, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, ALUControlE,
           ResultSrcE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, stall_m,
`ifdef EX_FORWARD_EN
           Rs1E, Rs2E, RdW, ResultW, RegWriteW,
`endif
    output stall_e, redirect, redirect_pc, valid_m, RegWriteM, MemWriteM, ResultSrcM,
           ALUResultM, WriteDataM, PCPlus4M, RdM, dbg_kill_cnt
  );
endinterface

// File: rtl/ex_stage.sv
// RV32 execute stage: ALU, branch/jump resolution, EX/MEM register, redirect and kill window.
// Optional operand forwarding is enabled with the EX_FORWARD_EN macro.
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int KILL_DEPTH = 2
) (
  input logic       clk,
  input logic       reset,
  ex_stage_if.slave bus
);
  localparam int KW = $clog2(KILL_DEPTH + 1);

  logic [KW-1:0]   kill_cnt_q, kill_cnt_d;
  logic            valid_m_q, regwrite_m_q, memwrite_m_q, redirect_q;
  logic [1:0]      resultsrc_m_q;
  logic [XLEN-1:0] alu_m_q, wdata_m_q, pcplus4_m_q, redirect_pc_q;
  logic [4:0]      rd_m_q;

  logic            accept, live, zero, taken;
  logic [XLEN-1:0] op_a, op_b, src_b, alu_res, target;

`ifdef EX_FORWARD_EN
  // EX/MEM wins over writeback because it holds the younger result.
  always_comb begin
    op_a = bus.RD1E;
    op_b = bus.RD2E;
    if (valid_m_q && regwrite_m_q && rd_m_q != 5'd0 && rd_m_q == bus.Rs1E)
      op_a = alu_m_q;
    else if (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == bus.Rs1E)
      op_a = bus.ResultW;
    if (valid_m_q && regwrite_m_q && rd_m_q != 5'd0 && rd_m_q == bus.Rs2E)
      op_b = alu_m_q;
    else if (bus.RegWriteW && bus.RdW != 5'd0 && bus.RdW == bus.Rs2E)
      op_b = bus.ResultW;
  end
`else
  assign op_a = bus.RD1E;
  assign op_b = bus.RD2E;
`endif

  assign src_b = bus.ALUSrcE ? bus.ImmExtE : op_b;

  always_comb begin
    alu_res = '0;
    case (bus.ALUControlE)
      3'b000: alu_res = op_a + src_b;
      3'b001: alu_res = op_a - src_b;
      3'b010: alu_res = op_a & src_b;
      3'b011: alu_res = op_a | src_b;
      3'b100: alu_res = op_a ^ src_b;
      3'b101: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(src_b)};
      3'b110: alu_res = op_a << src_b[4:0];
      3'b111: alu_res = op_a >> src_b[4:0];
      default: alu_res = '0;
    endcase
  end

  assign zero   = (alu_res == '0);
  assign accept = bus.valid_e & ~bus.stall_m;
  assign live   = accept & (kill_cnt_q == '0);
  assign taken  = live & ((bus.BranchE & zero) | bus.JumpE);
  assign target = bus.PCE + bus.ImmExtE;

  // Only consumed instructions move the window; bubbles and stalls leave it alone.
  always_comb begin
    kill_cnt_d = kill_cnt_q;
    if (taken)
      kill_cnt_d = KW'(KILL_DEPTH);
    else if (accept && kill_cnt_q != '0)
      kill_cnt_d = kill_cnt_q - KW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kill_cnt_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      valid_m_q     <= 1'b0;
      regwrite_m_q  <= 1'b0;
      memwrite_m_q  <= 1'b0;
      resultsrc_m_q <= '0;
      alu_m_q       <= '0;
      wdata_m_q     <= '0;
      pcplus4_m_q   <= '0;
      rd_m_q        <= '0;
    end else begin
      kill_cnt_q <= kill_cnt_d;
      redirect_q <= taken;
      if (taken)
        redirect_pc_q <= target;
      if (!bus.stall_m) begin
        valid_m_q    <= live;
        regwrite_m_q <= live & bus.RegWriteE;
        memwrite_m_q <= live & bus.MemWriteE;
        // Data fields only move for live instructions so squashed ones leave no trace.
        if (live) begin
          resultsrc_m_q <= bus.ResultSrcE;
          alu_m_q       <= alu_res;
          wdata_m_q     <= op_b;
          pcplus4_m_q   <= bus.PCPlus4E;
          rd_m_q        <= bus.RdE;
        end
      end
    end
  end

  assign bus.stall_e      = bus.stall_m;
  assign bus.redirect     = redirect_q;
  assign bus.redirect_pc  = redirect_pc_q;
  assign bus.valid_m      = valid_m_q;
  assign bus.RegWriteM    = regwrite_m_q;
  assign bus.MemWriteM    = memwrite_m_q;
  assign bus.ResultSrcM   = resultsrc_m_q;
  assign bus.ALUResultM   = alu_m_q;
  assign bus.WriteDataM   = wdata_m_q;
  assign bus.PCPlus4M     = pcplus4_m_q;
  assign bus.RdM          = rd_m_q;
  assign bus.dbg_kill_cnt = kill_cnt_q;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed test-plan steps followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_ex_stage;
  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  ex_stage_if #(.XLEN(32), .KW(2)) bus ();
  ex_stage #(.XLEN(32), .KILL_DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference model of the EX/MEM contents and feedback path.
  bit          m_valid, m_rw, m_mw, m_redir;
  logic [1:0]  m_rs;
  logic [31:0] m_alu, m_wd, m_pc4, m_rpc;
  logic [4:0]  m_rd;
  int          m_squash_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      3'd6: return 32'(64'(a) * (64'd1 << sh));
      default: return a / (32'd1 << sh);
    endcase
  endfunction

  task automatic check_outputs(input string p);
    chk({p, "_redirect"}, 32'(bus.redirect), 32'(m_redir));
    chk({p, "_redirect_pc"}, bus.redirect_pc, m_rpc);
    chk({p, "_valid_m"}, 32'(bus.valid_m), 32'(m_valid));
    chk({p, "_regwrite_m"}, 32'(bus.RegWriteM), 32'(m_rw));
    chk({p, "_memwrite_m"}, 32'(bus.MemWriteM), 32'(m_mw));
    if (m_valid) begin
      chk({p, "_alu_m"}, bus.ALUResultM, m_alu);
      chk({p, "_wdata_m"}, bus.WriteDataM, m_wd);
      chk({p, "_pc4_m"}, bus.PCPlus4M, m_pc4);
      chk({p, "_rd_m"}, 32'(bus.RdM), 32'(m_rd));
      chk({p, "_rsrc_m"}, 32'(bus.ResultSrcM), 32'(m_rs));
    end
  endtask

  task automatic drive(input bit v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit br, input bit jmp, input bit stall,
                       input logic [31:0] pc = 32'h0, input logic [31:0] imm = 32'h0,
                       input bit alusrc = 1'b0);
    bus.valid_e     = v;
    bus.ALUControlE = op;
    bus.RD1E        = a;
    bus.RD2E        = b;
    bus.RdE         = rd;
    bus.BranchE     = br;
    bus.JumpE       = jmp;
    bus.stall_m     = stall;
    bus.PCE         = pc;
    bus.ImmExtE     = imm;
    bus.ALUSrcE     = alusrc;
    bus.PCPlus4E    = pc + 32'd4;
    bus.RegWriteE   = ~br;
    bus.MemWriteE   = 1'b0;
    bus.ResultSrcE  = rd[1:0];
  endtask

  task automatic step(input string p);
    bit          accept, live, taken;
    logic [31:0] r;
    #1;
    chk({p, "_stall_e"}, 32'(bus.stall_e), 32'(bus.stall_m));
    accept = bus.valid_e && !bus.stall_m;
    live   = accept && m_squash_left == 0;
    r      = ref_alu(bus.ALUControlE, bus.RD1E, bus.ALUSrcE ? bus.ImmExtE : bus.RD2E);
    taken  = live && ((bus.BranchE && r == 0) || bus.JumpE);
    if (!bus.stall_m) begin
      m_valid = live;
      m_rw    = live && bus.RegWriteE;
      m_mw    = live && bus.MemWriteE;
      if (live) begin
        m_alu = r;
        m_wd  = bus.RD2E;
        m_pc4 = bus.PCPlus4E;
        m_rd  = bus.RdE;
        m_rs  = bus.ResultSrcE;
      end
    end
    m_redir = taken;
    if (taken) m_rpc = bus.PCE + bus.ImmExtE;
    if (taken) m_squash_left = 2;
    else if (accept && m_squash_left > 0) m_squash_left--;
    @(posedge clk);
    #1;
    check_outputs(p);
  endtask

  task automatic do_reset(input string p);
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_valid = 0; m_rw = 0; m_mw = 0; m_redir = 0; m_rs = 0;
    m_alu = 0; m_wd = 0; m_pc4 = 0; m_rpc = 0; m_rd = 0; m_squash_left = 0;
    check_outputs(p);
    chk({p, "_alu_zero"}, bus.ALUResultM, 32'd0);
    chk({p, "_rd_zero"}, 32'(bus.RdM), 32'd0);
  endtask

  initial begin
`ifdef EX_FORWARD_EN
    bus.Rs1E = 5'd0; bus.Rs2E = 5'd0; bus.RdW = 5'd0; bus.ResultW = 32'd0; bus.RegWriteW = 1'b0;
`endif
    reset = 1'b1;
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    do_reset("reset");

    // Directed ALU cases with literal expectations.
    drive(1, 3'd0, 32'd5, 32'd7, 5'd3, 0, 0, 0);
    step("add");
    chk("add_lit_alu", bus.ALUResultM, 32'd12);
    chk("add_lit_rd", 32'(bus.RdM), 32'd3);
    chk("add_lit_valid", 32'(bus.valid_m), 32'd1);
    chk("add_lit_rw", 32'(bus.RegWriteM), 32'd1);
    drive(1, 3'd1, 32'd0, 32'd1, 5'd4, 0, 0, 0);
    step("sub");
    chk("sub_lit_alu", bus.ALUResultM, 32'hFFFF_FFFF);
    drive(1, 3'd5, 32'hFFFF_FFFF, 32'd1, 5'd5, 0, 0, 0);
    step("slt");
    chk("slt_lit_alu", bus.ALUResultM, 32'd1);
    drive(1, 3'd6, 32'd1, 32'h21, 5'd6, 0, 0, 0);
    step("sll");
    chk("sll_lit_alu", bus.ALUResultM, 32'd2);

    // Taken beq, then two squashed and one committed instruction.
    drive(1, 3'd1, 32'd9, 32'd9, 5'd0, 1, 0, 0, 32'h100, 32'h20);
    step("beq");
    chk("beq_lit_redirect", 32'(bus.redirect), 32'd1);
    chk("beq_lit_pc", bus.redirect_pc, 32'h120);
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd0, 32'(i), 32'd1, 5'd7, 0, 0, 0);
      step("beq_after");
      chk("beq_after_lit_valid", 32'(bus.valid_m), (i == 2) ? 32'd1 : 32'd0);
      chk("beq_after_lit_redirect", 32'(bus.redirect), 32'd0);
    end

    // jal followed by bubbles: the window only counts real instructions.
    drive(1, 3'd0, 0, 0, 5'd1, 0, 1, 0, 32'h200, 32'h40);
    step("jal");
    chk("jal_lit_pc", bus.redirect_pc, 32'h240);
    for (int i = 0; i < 3; i++) begin
      drive(0, 3'd0, 32'd1, 32'd1, 5'd8, 0, 0, 0);
      step("jal_bubble");
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 3'd0, 32'd10, 32'(i), 5'd9, 0, 0, 0);
      step("jal_after");
      chk("jal_after_lit_rw", 32'(bus.RegWriteM), (i == 2) ? 32'd1 : 32'd0);
    end

    // Taken branch held off by a stall, then released.
    for (int i = 0; i < 4; i++) begin
      drive(1, 3'd1, 32'd3, 32'd3, 5'd0, 1, 0, 1, 32'h300, 32'h10);
      step("stall");
      chk("stall_lit_redirect", 32'(bus.redirect), 32'd0);
      chk("stall_lit_alu_frozen", bus.ALUResultM, 32'd12);
    end
    drive(1, 3'd1, 32'd3, 32'd3, 5'd0, 1, 0, 0, 32'h300, 32'h10);
    step("stall_release");
    chk("stall_release_lit_redirect", 32'(bus.redirect), 32'd1);
    chk("stall_release_lit_pc", bus.redirect_pc, 32'h310);

    // Reset with one squash still pending.
    drive(1, 3'd0, 32'd1, 32'd1, 5'd2, 0, 0, 0);
    step("mid_window");
    do_reset("mid_reset");
    drive(1, 3'd0, 32'd20, 32'd22, 5'd10, 0, 0, 0);
    step("post_reset");
    chk("post_reset_lit_valid", 32'(bus.valid_m), 32'd1);
    chk("post_reset_lit_alu", bus.ALUResultM, 32'd42);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      logic [2:0]  op;
      bit          br, jmp;
      if ($urandom_range(99) < 1) begin
        do_reset("rnd_reset");
        continue;
      end
      a   = $urandom;
      b   = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom;
      op  = 3'($urandom_range(7));
      br  = $urandom_range(99) < 15;
      jmp = !br && $urandom_range(99) < 5;
      if (br && $urandom_range(1) == 1) begin
        b  = a;
        op = 3'd1;
      end
      drive($urandom_range(99) >= 20, op, a, b, 5'($urandom_range(31)), br, jmp,
            $urandom_range(99) < 15, $urandom, $urandom, br ? 1'b0 : 1'($urandom_range(1)));
      bus.MemWriteE = 1'($urandom_range(1));
      bus.RegWriteE = 1'($urandom_range(1));
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
